mdu_unit: RTL and testbench

- Multiply/divide unit in the Execute stage; serves as the responder for the mult/div-use indication that Decode raises.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency into HI/LO; handles MFHI/MFLO/MTHI/MTLO.
- Produces the pipeline stall request for any mult/div-class instruction waiting in Decode while the unit is starting or busy.

---
 rtl/mdu_unit.sv | 143 ++++++++++++++
 tb/tb_mdu_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the Execute stage.
// Results are staged in a pending pair and committed to HI/LO when the busy countdown expires.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        D_mlu_use,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic        mdu_stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_p_q, hi_p_d, lo_p_q, lo_p_d;
  logic [3:0]  count_q, count_d;
  logic        wr_p_q, wr_p_d;

  logic        is_mul_s, is_div_s, sgn_s;
  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic [31:0] dvd_s, dvs_s, dvs_safe_s, quo_s, rem_s;
  logic [31:0] res_hi_s, res_lo_s;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  assign busy      = (count_q != 4'd0);
  assign is_mul_s  = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div_s  = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign start     = md_valid && (is_mul_s || is_div_s) && !busy;
  assign mdu_stall = D_mlu_use && (start || busy);

  // Operand conditioning and arithmetic for the start-cycle result
  always_comb begin
    sgn_s      = (md_op == OP_MULT) || (md_op == OP_DIV);
    mul_a_s    = {{32{sgn_s & md_a[31]}}, md_a};
    mul_b_s    = {{32{sgn_s & md_b[31]}}, md_b};
    prod_s     = mul_a_s * mul_b_s;
    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly
    dvd_s      = sgn_s ? abs32(md_a) : md_a;
    dvs_s      = sgn_s ? abs32(md_b) : md_b;
    dvs_safe_s = (dvs_s == 32'd0) ? 32'd1 : dvs_s;
    quo_s      = dvd_s / dvs_safe_s;
    rem_s      = dvd_s % dvs_safe_s;
    if (sgn_s && (md_a[31] ^ md_b[31])) begin
      quo_s = 32'd0 - quo_s;
    end else begin
      quo_s = quo_s;
    end
    if (sgn_s && md_a[31]) begin
      rem_s = 32'd0 - rem_s;
    end else begin
      rem_s = rem_s;
    end
    if (is_div_s) begin
      res_hi_s = rem_s;
      res_lo_s = quo_s;
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
  end

  // Next-state: countdown/commit while busy, launch on start, HI/LO moves otherwise
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    count_d = count_q;
    wr_p_d  = wr_p_q;
    if (busy) begin
      count_d = count_q - 4'd1;
      if ((count_q == 4'd1) && wr_p_q) begin
        hi_d = hi_p_q;
        lo_d = lo_p_q;
      end else begin
        hi_d = hi_q;
      end
    end else if (start) begin
      hi_p_d  = res_hi_s;
      lo_p_d  = res_lo_s;
      count_d = is_div_s ? DIV_N : MULT_N;
      wr_p_d  = !(is_div_s && (md_b == 32'd0));
    end else if (md_valid) begin
      case (md_op)
        OP_MTHI: hi_d = md_a;
        OP_MTLO: lo_d = md_a;
        default: hi_d = hi_q;
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_p_q  <= 32'd0;
      lo_p_q  <= 32'd0;
      count_q <= 4'd0;
      wr_p_q  <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      count_q <= count_d;
      wr_p_q  <= wr_p_d;
    end
  end

  // Move-from read port
  always_comb begin
    case (md_op)
      OP_MFHI: md_out = hi_q;
      OP_MFLO: md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: expected HI/LO pairs are queued at issue and popped at readback.
module tb_mdu_unit;
  logic        clk, reset, md_valid, D_mlu_use;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b, md_out;
  logic        start, busy, mdu_stall;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m, lo_m;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .D_mlu_use(D_mlu_use),
    .start(start), .busy(busy), .md_out(md_out), .mdu_stall(mdu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic du,
                        input logic [31:0] eh, input logic [31:0] el);
    logic [63:0] e;
    sb_q.push_back({eh, el});
    next_cycle();
    md_valid = 1'b1; md_op = op; md_a = a; md_b = b; D_mlu_use = du;
    #1;
    chk({tag, "_start"}, 32'(start), 32'd1);
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
    chk({tag, "_stall_start"}, 32'(mdu_stall), 32'(du));
    for (int i = 0; i < n; i++) begin
      next_cycle();
      md_valid = 1'b0; md_op = 4'd0;
      #1;
      chk($sformatf("%s_busy%0d", tag, i + 1), 32'(busy), 32'd1);
      chk($sformatf("%s_stall%0d", tag, i + 1), 32'(mdu_stall), 32'(du));
      chk($sformatf("%s_nostart%0d", tag, i + 1), 32'(start), 32'd0);
    end
    next_cycle();
    md_valid = 1'b1; md_op = 4'd5;
    #1;
    e = sb_q.pop_front();
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_stall"}, 32'(mdu_stall), 32'd0);
    chk({tag, "_hi"}, md_out, e[63:32]);
    next_cycle();
    md_op = 4'd6;
    #1;
    chk({tag, "_lo"}, md_out, e[31:0]);
    md_valid = 1'b0; md_op = 4'd0; D_mlu_use = 1'b0;
    hi_m = eh; lo_m = el;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rp;
    reset = 1'b0; md_valid = 1'b0; md_op = 4'd0; md_a = 32'd0; md_b = 32'd0; D_mlu_use = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    #12;
    md_op = 4'd5; #1;
    chk("rst_hi", md_out, 32'd0);
    md_op = 4'd6; #1;
    chk("rst_lo", md_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    md_op = 4'd0;
    next_cycle();
    reset = 1'b1;

    run_op("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'd1, 32'h7FFFFFFC);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'd0, 32'h80000000);
    run_op("mult_min", 4'd1, 32'h80000000, 32'hFFFFFFFF, 5, 1'b0, 32'd0, 32'h80000000);

    // MTHI followed immediately by MFHI
    next_cycle();
    md_valid = 1'b1; md_op = 4'd7; md_a = 32'h12345678; #1;
    chk("mthi_nobusy", 32'(busy), 32'd0);
    next_cycle();
    md_op = 4'd5; #1;
    chk("mthi_read", md_out, 32'h12345678);
    hi_m = 32'h12345678;
    next_cycle();
    md_op = 4'd8; md_a = 32'hCAFEF00D;
    next_cycle();
    md_op = 4'd6; #1;
    chk("mtlo_read", md_out, 32'hCAFEF00D);
    lo_m = 32'hCAFEF00D;
    md_valid = 1'b0; md_op = 4'd0;

    run_op("div_zero", 4'd3, 32'd55, 32'd0, 10, 1'b1, hi_m, lo_m);

    for (int k = 0; k < 3; k++) begin
      ra = $urandom; rb = $urandom | 32'd1;
      rp = {32'd0, ra} * {32'd0, rb};
      run_op($sformatf("rmultu%0d", k), 4'd2, ra, rb, 5, 1'b0, rp[63:32], rp[31:0]);
      run_op($sformatf("rdivu%0d", k), 4'd4, ra, rb, 10, 1'b1, ra % rb, ra / rb);
    end

    // Reset pulled during busy cycle 3 of a DIV
    next_cycle();
    md_valid = 1'b1; md_op = 4'd3; md_a = 32'd100; md_b = 32'd7;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      md_valid = 1'b0; md_op = 4'd0;
    end
    #1;
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0; #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    md_op = 4'd5; #1;
    chk("rst_mid_hi", md_out, 32'd0);
    md_op = 4'd6; #1;
    chk("rst_mid_lo", md_out, 32'd0);
    md_op = 4'd0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    chk("rst_post_busy", 32'(busy), 32'd0);

    run_op("mult_42", 4'd1, 32'd6, 32'd7, 5, 1'b1, 32'd0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
